// File: rtl/bs_pkg.sv
// Shared constants and types for the bus-steering blocks.
// Lane count, select width and default bus/counter widths live here.
package bs_pkg;

    localparam int LANES    = 4;
    localparam int SEL_W    = 2;
    localparam int BS_WIDTH = 4;
    localparam int BS_CNT_W = 8;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // One-hot view of a lane select.
    function automatic logic [LANES-1:0] sel_onehot(input lane_sel_t sel);
        logic [LANES-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lane_hold_reg.sv
// One-entry register slice for a single output lane.
// Holds one word until the consumer takes it; counts loads.
module lane_hold_reg
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH,
    parameter int CNT_W = BS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             take,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    // Empty, or emptying this cycle, so a refill cannot bubble.
    assign ready = !valid | take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
            cnt   <= cnt + 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bs_4_demux14_reg.sv
// Registered 1:4 bus demultiplexer with per-lane valid/ready holding.
// Select decode and ready steering only; storage lives in the lanes.
module bs_4_demux14_reg
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH,
    parameter int CNT_W = BS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A0,
    output logic [WIDTH-1:0] A1,
    output logic [WIDTH-1:0] A2,
    output logic [WIDTH-1:0] A3,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    lane_sel_t        sel;
    logic [LANES-1:0] sel_oh;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] load;
    logic             accept;
    logic [WIDTH-1:0] lane_data [LANES];
    logic [CNT_W-1:0] lane_cnt  [LANES];

    assign sel      = {s1, s0};
    assign sel_oh   = sel_onehot(sel);
    assign in_ready = lane_ready[sel];
    assign accept   = in_valid & in_ready;
    assign load     = sel_oh & {LANES{accept}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_hold_reg #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .din   (din),
            .take  (out_ready[i]),
            .ready (lane_ready[i]),
            .valid (out_valid[i]),
            .data  (lane_data[i]),
            .cnt   (lane_cnt[i])
        );
    end

    assign A0   = lane_data[0];
    assign A1   = lane_data[1];
    assign A2   = lane_data[2];
    assign A3   = lane_data[3];
    assign cnt0 = lane_cnt[0];
    assign cnt1 = lane_cnt[1];
    assign cnt2 = lane_cnt[2];
    assign cnt3 = lane_cnt[3];

endmodule

// File: tb/tb_bs_4_demux14_reg.sv
// Scoreboard bench for the registered 1:4 bus demultiplexer.
// Each lane is modelled as a queue of words awaiting its consumer.
module tb_bs_4_demux14_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic       s0, s1;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A0, A1, A2, A3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    int errors = 0;
    int checks = 0;

    logic [3:0] q    [4][$];
    logic [3:0] last [4];
    logic [7:0] mcnt [4];

    logic [3:0] a_arr [4];
    logic [7:0] c_arr [4];

    assign a_arr[0] = A0;
    assign a_arr[1] = A1;
    assign a_arr[2] = A2;
    assign a_arr[3] = A3;
    assign c_arr[0] = cnt0;
    assign c_arr[1] = cnt1;
    assign c_arr[2] = cnt2;
    assign c_arr[3] = cnt3;

    bs_4_demux14_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .s0        (s0),
        .s1        (s1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A0        (A0),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last[i] = '0;
            mcnt[i] = '0;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s,
                        input logic [3:0] d, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        {s1, s0}  = s;
        din       = d;
        out_ready = r;
    endtask

    // Monitor: compare held state with the model, then apply this
    // cycle's drains and accept to the model.
    logic [1:0] m_sel;
    logic       m_rdy;
    logic [3:0] m_exp_a;

    always @(negedge clk) begin
        if (rst_n) begin
            m_sel = {s1, s0};
            for (int i = 0; i < 4; i++) begin
                m_exp_a = (q[i].size() != 0) ? q[i][0] : last[i];
                chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]),
                    32'(q[i].size() != 0));
                chk($sformatf("A%0d", i), 32'(a_arr[i]), 32'(m_exp_a));
                chk($sformatf("cnt%0d", i), 32'(c_arr[i]), 32'(mcnt[i]));
            end
            m_rdy = (q[m_sel].size() == 0) || out_ready[m_sel];
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            for (int i = 0; i < 4; i++)
                if (q[i].size() != 0 && out_ready[i])
                    last[i] = q[i].pop_front();
            if (in_valid && m_rdy) begin
                q[m_sel].push_back(din);
                mcnt[m_sel] = mcnt[m_sel] + 8'd1;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        {s1, s0}  = 2'd0;
        in_valid  = 1'b0;
        out_ready = '0;
        model_reset();
        #12;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst A", 32'({A3, A2, A1, A0}), 32'h0);
        chk("rst cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Sequential fill, no consumers ready.
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 4'(1 << i), 4'b0000);
        step(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        chk("fill A", 32'({A3, A2, A1, A0}), 32'h8421);
        chk("fill out_valid", 32'(out_valid), 32'hF);
        chk("fill cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);

        // Backpressure on lane 2.
        step(1'b1, 2'd2, 4'hF, 4'b0000);
        @(negedge clk);
        chk("bp in_ready low", 32'(in_ready), 32'h0);
        step(1'b1, 2'd2, 4'hF, 4'b0000);
        @(negedge clk);
        chk("bp A2 held", 32'(A2), 32'h4);
        step(1'b1, 2'd2, 4'hF, 4'b0100);
        #1;
        chk("bp in_ready comb", 32'(in_ready), 32'h1);
        step(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        chk("bp A2 refill", 32'(A2), 32'hF);
        chk("bp valid kept", 32'(out_valid[2]), 32'h1);

        // Streaming into lane 1 with its consumer always ready.
        for (int k = 1; k <= 8; k++)
            step(1'b1, 2'd1, 4'(k), 4'b0010);
        step(1'b0, 2'd0, 4'h0, 4'b0010);
        @(negedge clk);
        chk("stream A1", 32'(A1), 32'h8);
        chk("stream cnt1", 32'(cnt1), 32'd9);
        step(1'b0, 2'd0, 4'h0, 4'b0000);

        // Select change while stalled on lane 3.
        step(1'b0, 2'd0, 4'h0, 4'b0001);
        step(1'b1, 2'd3, 4'h9, 4'b0000);
        @(negedge clk);
        chk("selchg stall", 32'(in_ready), 32'h0);
        step(1'b1, 2'd0, 4'h9, 4'b0000);
        step(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        chk("selchg A0", 32'(A0), 32'h9);
        chk("selchg A3", 32'(A3), 32'h8);
        chk("selchg cnt3", 32'(cnt3), 32'h1);

        // Asynchronous reset between clock edges.
        step(1'b1, 2'd1, 4'h3, 4'b0000);
        step(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'h0);
        chk("arst A", 32'({A3, A2, A1, A0}), 32'h0);
        chk("arst cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Counter wrap on lane 0.
        step(1'b1, 2'd1, 4'h6, 4'b0000);
        for (int k = 0; k < 256; k++)
            step(1'b1, 2'd0, 4'($urandom), 4'b0001);
        step(1'b0, 2'd0, 4'h0, 4'b0000);
        @(negedge clk);
        chk("wrap cnt0", 32'(cnt0), 32'h0);
        chk("wrap cnt1", 32'(cnt1), 32'h1);
        chk("wrap cnt23", 32'({cnt3, cnt2}), 32'h0);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom));
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'd0, 4'h0, 4'hF);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
